// File: rtl/solver_pio_pkg.sv
// Shared definitions for the solver PIO family.
//   pio_addr_e      : Avalon-MM register addresses
//   ST_*            : STATUS register bit indices
//   IM_*            : IRQMASK register bit indices
package solver_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_COUNT   = 2'd3
  } pio_addr_e;

  localparam int unsigned ST_FULL = 0;
  localparam int unsigned ST_OVR  = 1;

  localparam int unsigned IM_FULL = 0;
  localparam int unsigned IM_OVR  = 1;

endpackage

// File: rtl/solver_pio_hold_reg.sv
// One-entry holding register between the solver stream and the CPU.
//   clk, reset   : clock, synchronous active-high reset
//   i_data       : word from the solver
//   i_valid      : i_data valid this cycle
//   i_pop        : CPU is consuming the held word this cycle
//   i_ovr_clr    : clear the overrun flag (a new overrun wins)
//   o_hold       : held word
//   o_full       : a word is held
//   o_overrun    : a word was dropped since the last clear
//   o_ready      : a word can be accepted without overrun
//   o_accept     : a word is captured this cycle
module solver_pio_hold_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_pop,
  input  logic                  i_ovr_clr,
  output logic [DATA_WIDTH-1:0] o_hold,
  output logic                  o_full,
  output logic                  o_overrun,
  output logic                  o_ready,
  output logic                  o_accept
);

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_full;
  logic                  r_overrun;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_drop;

  // A pop in the same cycle frees the slot, so streaming back-to-back works.
  assign w_ready  = ~r_full | i_pop;
  assign w_accept = i_valid & w_ready;
  assign w_drop   = i_valid & ~w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold    <= '0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= i_data;
        r_full <= 1'b1;
      end else if (i_pop) begin
        r_full <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_hold    = r_hold;
  assign o_full    = r_full;
  assign o_overrun = r_overrun;
  assign o_ready   = w_ready;
  assign o_accept  = w_accept;

endmodule

// File: rtl/solver_operand_pio.sv
// Avalon-MM slave input PIO carrying solver words to the CPU.
//   clk, reset           : clock, synchronous active-high reset
//   address/chipselect/
//   read_n/write_n/
//   writedata/readdata   : Avalon-MM slave, zero wait states, read latency 0
//   in_data/in_valid     : word stream from the solver
//   in_ready             : word can be accepted without overrun
//   irq                  : level interrupt (full and/or overrun, maskable)
// Registers: 0 DATA (RO, read pops), 1 STATUS (full RO, overrun W1C),
//            2 IRQMASK (RW, 2 bits), 3 COUNT (RO, any write clears).
module solver_operand_pio
  import solver_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  irq
);

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_ovr_clr;
  logic                  w_cnt_clr;
  logic                  w_mask_wr;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_overrun;
  logic [DATA_WIDTH-1:0] w_hold;
  logic                  w_unused_wdata;
  pio_addr_e             w_addr;

  logic [1:0]            r_irqmask;
  logic [CNT_WIDTH-1:0]  r_count;

  assign w_addr = pio_addr_e'(address);
  assign w_rd   = chipselect & ~read_n;
  assign w_wr   = chipselect & ~write_n;

  // A simultaneous write suppresses the read side effect.
  assign w_pop     = w_rd & ~w_wr & (w_addr == ADDR_DATA);
  assign w_ovr_clr = w_wr & (w_addr == ADDR_STATUS) & writedata[ST_OVR];
  assign w_mask_wr = w_wr & (w_addr == ADDR_IRQMASK);
  assign w_cnt_clr = w_wr & (w_addr == ADDR_COUNT);

  assign w_unused_wdata = ^writedata[31:2];

  solver_pio_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .i_data    (in_data),
    .i_valid   (in_valid),
    .i_pop     (w_pop),
    .i_ovr_clr (w_ovr_clr),
    .o_hold    (w_hold),
    .o_full    (w_full),
    .o_overrun (w_overrun),
    .o_ready   (in_ready),
    .o_accept  (w_accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= '0;
      r_count   <= '0;
    end else begin
      if (w_mask_wr) begin
        r_irqmask <= writedata[1:0];
      end
      // Clear and accept together leave the accepted word counted.
      if (w_cnt_clr) begin
        r_count <= w_accept ? CNT_WIDTH'(1) : '0;
      end else if (w_accept) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (w_addr)
      ADDR_DATA:    readdata[DATA_WIDTH-1:0] = w_hold;
      ADDR_STATUS: begin
        readdata[ST_FULL] = w_full;
        readdata[ST_OVR]  = w_overrun;
      end
      ADDR_IRQMASK: readdata[1:0] = r_irqmask;
      ADDR_COUNT:   readdata[CNT_WIDTH-1:0] = r_count;
      default:      readdata = '0;
    endcase
  end

  assign irq = (w_full & r_irqmask[IM_FULL]) | (w_overrun & r_irqmask[IM_OVR]);

endmodule

// File: tb/tb_solver_operand_pio.sv
// Scoreboard bench for solver_operand_pio: each bus read pushes its expected
// readdata (and optionally irq/in_ready) into a queue; a negedge monitor pops
// and compares whenever a read strobe is presented.
module tb_solver_operand_pio;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          read_n;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          irq;

  always #5 clk = ~clk;

  solver_operand_pio #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  typedef struct {
    logic [31:0] rd;
    logic        side;
    logic        irq;
    logic        rdy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    if (chipselect && !read_n) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: readdata=%h, no expectation queued", readdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (readdata !== e.rd) begin
          miscompares++;
          $display("FAIL %s: readdata=%h expected %h", e.name, readdata, e.rd);
        end
        if (e.side) begin
          vectors += 2;
          if (irq !== e.irq) begin
            miscompares++;
            $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq);
          end
          if (in_ready !== e.rdy) begin
            miscompares++;
            $display("FAIL %s_ready: in_ready=%b expected %b", e.name, in_ready, e.rdy);
          end
        end
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
  endtask

  task automatic bus(input logic cs, input logic rn, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd, input logic iv, input logic [31:0] id);
    chipselect = cs;
    read_n     = rn;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_valid   = iv;
    in_data    = id;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_rd(input logic [31:0] e, input logic side, input logic ei,
                           input logic er, input string nm);
    exp_t x;
    x.rd = e; x.side = side; x.irq = ei; x.rdy = er; x.name = nm;
    q.push_back(x);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    expect_rd(e, 1'b0, 1'b0, 1'b0, nm);
    bus(1'b1, 1'b0, 1'b1, a, '0, 1'b0, '0);
  endtask

  task automatic rd_side(input logic [1:0] a, input logic [31:0] e, input logic ei,
                         input logic er, input string nm);
    expect_rd(e, 1'b1, ei, er, nm);
    bus(1'b1, 1'b0, 1'b1, a, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] d);
    bus(1'b0, 1'b1, 1'b1, 2'd0, '0, 1'b1, d);
  endtask

  task automatic push_rd(input logic [31:0] d, input logic [31:0] e, input string nm);
    expect_rd(e, 1'b0, 1'b0, 1'b0, nm);
    bus(1'b1, 1'b0, 1'b1, 2'd0, '0, 1'b1, d);
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, wd, 1'b1, d);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    rd_side(2'd0, 32'h0, 1'b0, 1'b1, "rst_data");
    rd_side(2'd1, 32'h0, 1'b0, 1'b1, "rst_status");
    rd(2'd2, 32'h0, "rst_irqmask");
    rd(2'd3, 32'h0, "rst_count");

    // Single capture and pop; a read with chipselect low must not pop
    push(32'hDEADBEEF);
    bus(1'b0, 1'b0, 1'b1, 2'd0, '0, 1'b0, '0);
    rd(2'd1, 32'h1, "cap_status");
    rd_side(2'd0, 32'hDEADBEEF, 1'b0, 1'b1, "cap_data");
    rd(2'd1, 32'h0, "pop_status");
    rd(2'd3, 32'h1, "cap_count");

    // Overrun: second word dropped
    push(32'h11111111);
    push(32'h22222222);
    rd(2'd1, 32'h3, "ovr_status");
    rd(2'd3, 32'h2, "ovr_count");
    wr(2'd1, 32'h2);
    rd_side(2'd1, 32'h1, 1'b0, 1'b0, "w1c_status");
    rd(2'd0, 32'h11111111, "ovr_data");
    rd(2'd1, 32'h0, "ovr_pop_status");

    // Back-to-back streaming: capture in the same cycle as a pop
    push(32'h44444444);
    push_rd(32'h33333333, 32'h44444444, "stream_old");
    rd(2'd1, 32'h1, "stream_status");
    rd(2'd3, 32'h4, "stream_count");
    rd(2'd0, 32'h33333333, "stream_new");
    rd(2'd1, 32'h0, "stream_empty");

    // Full interrupt
    wr(2'd2, 32'hFFFF_FFF1);
    rd_side(2'd2, 32'h1, 1'b0, 1'b1, "im_full_empty");
    push(32'h55555555);
    rd_side(2'd1, 32'h1, 1'b1, 1'b0, "irq_full");
    rd_side(2'd0, 32'h55555555, 1'b1, 1'b1, "irq_pop_data");
    rd_side(2'd1, 32'h0, 1'b0, 1'b1, "irq_cleared");

    // Overrun interrupt, W1C, and set winning over clear
    wr(2'd2, 32'h2);
    push(32'h66666666);
    push(32'h77777777);
    rd_side(2'd1, 32'h3, 1'b1, 1'b0, "irq_ovr");
    wr(2'd1, 32'h2);
    rd_side(2'd1, 32'h1, 1'b0, 1'b0, "irq_ovr_w1c");
    push_wr(2'd1, 32'h2, 32'h88888888);
    rd_side(2'd1, 32'h3, 1'b1, 1'b0, "ovr_set_wins");
    wr(2'd1, 32'h2);
    rd(2'd1, 32'h1, "ovr_reclear");
    rd(2'd0, 32'h66666666, "ovr_kept_data");

    // Read and write together: read side effect suppressed
    push(32'h99999999);
    expect_rd(32'h99999999, 1'b0, 1'b0, 1'b0, "rdwr_data");
    bus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, '0);
    rd(2'd1, 32'h1, "rdwr_nopop");
    rd(2'd0, 32'h99999999, "rdwr_pop");
    rd(2'd3, 32'h7, "count7");

    // Count clear, and clear together with accept
    wr(2'd3, 32'h1234);
    rd(2'd3, 32'h0, "count_clr");
    push_wr(2'd3, 32'h0, 32'h000000AB);
    rd(2'd3, 32'h1, "clr_accept");
    rd(2'd0, 32'h000000AB, "clr_accept_data");

    // Count wrap at all-ones
    push(32'd1);
    for (int unsigned i = 2; i <= 254; i++) begin
      push_rd(i, i - 1, "wrap_stream");
    end
    rd(2'd3, 32'hFF, "count_max");
    push_rd(32'd255, 32'd254, "wrap_last");
    rd(2'd3, 32'h0, "count_wrap");

    // Reset while full and in_valid high
    wr(2'd2, 32'h3);
    rd_side(2'd1, 32'h1, 1'b1, 1'b0, "pre_reset");
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    idle();
    rd_side(2'd0, 32'h0, 1'b0, 1'b1, "mid_rst_data");
    rd(2'd1, 32'h0, "mid_rst_status");
    rd(2'd2, 32'h0, "mid_rst_irqmask");
    rd(2'd3, 32'h0, "mid_rst_count");

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
